// File: rtl/audio_sample_scheduler.sv
// -----------------------------------------------------------------------------
// audio_sample_scheduler
//
// Buffers signed audio samples from a source in a small FIFO and issues one
// sample to the output device every DIVIDER clock cycles. Playback begins only
// after PREFILL samples are buffered. If the FIFO is empty when a sample is due
// (underrun), silence (0) is issued, the underrun counter increments and the
// scheduler goes back to prefilling. Dropping enable returns to IDLE and
// discards all buffered samples.
//
// Parameters
//   DIVIDER  clock cycles per output sample period (2..65535)
//   DEPTH    FIFO depth in entries (power of two, 2..16)
//   PREFILL  occupancy needed before playback starts (1..DEPTH)
//
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   enable          playback enable
//   src_valid       source offers a sample on src_data
//   src_data        signed 32-bit sample from the source
//   src_ready       combinational: sample accepted this cycle
//   audio           registered signed sample for the output device
//   sample_tick     one-cycle pulse when audio carries a newly issued sample
//   state           0 IDLE, 1 FILL, 2 RUN
//   underrun_count  saturating count of underrun events
// -----------------------------------------------------------------------------
module audio_sample_scheduler #(
    parameter int DIVIDER = 256,
    parameter int DEPTH   = 4,
    parameter int PREFILL = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               src_valid,
    input  logic signed [31:0] src_data,
    output logic               src_ready,
    output logic signed [31:0] audio,
    output logic               sample_tick,
    output logic [1:0]         state,
    output logic [15:0]        underrun_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic signed [31:0] audio_q, audio_d;
    logic               tick_q, tick_d;
    logic [15:0]        underrun_q, underrun_d;

    logic signed [31:0] mem [DEPTH];

    logic push;
    logic wrap;
    logic pop;

    // No bypass: a full FIFO refuses data even on a cycle where it pops.
    assign src_ready = enable && (state_q != S_IDLE) && (occ_q != OCC_W'(DEPTH));
    assign push      = src_valid && src_ready;

    // A wrap while enable is low is suppressed: the disable takes priority.
    assign wrap = enable && (state_q == S_RUN) && (cnt_q == 16'(DIVIDER - 1));
    // Pop uses the pre-edge occupancy, so a sample pushed on an underrun edge
    // cannot satisfy that same edge.
    assign pop  = wrap && (occ_q != '0);

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        audio_d    = audio_q;
        tick_d     = 1'b0;
        underrun_d = underrun_q;

        if (!enable) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = S_FILL;
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    occ_d    = '0;
                end
                S_FILL: begin
                    cnt_d = '0;
                    if (occ_q >= OCC_W'(PREFILL)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (pop) begin
                            audio_d = mem[rd_ptr_q];
                        end else begin
                            audio_d = '0;
                            state_d = S_FILL;
                            if (underrun_q != 16'hFFFF) begin
                                underrun_d = underrun_q + 16'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            audio_q    <= '0;
            tick_q     <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            audio_q    <= audio_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

    // NOTE: the sample storage is deliberately not reset; emptiness is defined
    // by the pointers and occupancy, so stale contents are never read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= src_data;
        end
    end

    assign audio          = audio_q;
    assign sample_tick    = tick_q;
    assign state          = state_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
module tb_audio_sample_scheduler;

    localparam int DIVIDER = 4;
    localparam int DEPTH   = 4;
    localparam int PREFILL = 2;

    // ---------------- main DUT (DIVIDER=4, DEPTH=4, PREFILL=2) ----------------
    logic               clock = 1'b0;
    logic               reset_n;
    logic               enable    = 1'b0;
    logic               src_valid = 1'b0;
    logic signed [31:0] src_data  = '0;
    logic               src_ready;
    logic signed [31:0] audio;
    logic               sample_tick;
    logic [1:0]         state;
    logic [15:0]        underrun_count;

    audio_sample_scheduler #(.DIVIDER(DIVIDER), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .audio          (audio),
        .sample_tick    (sample_tick),
        .state          (state),
        .underrun_count (underrun_count)
    );

    // ---------------- saturation DUT (DIVIDER=2, DEPTH=4, PREFILL=1) ----------
    logic               reset2_n;
    logic               enable2 = 1'b0;
    logic               valid2  = 1'b0;
    logic signed [31:0] data2   = '0;
    logic               ready2;
    logic signed [31:0] audio2;
    logic               tick2;
    logic [1:0]         state2;
    logic [15:0]        under2;

    audio_sample_scheduler #(.DIVIDER(2), .DEPTH(4), .PREFILL(1)) dut2 (
        .clock          (clock),
        .reset_n        (reset2_n),
        .enable         (enable2),
        .src_valid      (valid2),
        .src_data       (data2),
        .src_ready      (ready2),
        .audio          (audio2),
        .sample_tick    (tick2),
        .state          (state2),
        .underrun_count (under2)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------------------
    // Playback is described as: a queue of buffered samples, a mode, and the
    // number of cycles spent playing; a sample is due every DIVIDER-th cycle.
    typedef struct {
        logic [31:0] audio;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_fifo[$];
    int          m_state = 0;   // 0 idle, 1 prefilling, 2 playing
    int          m_run   = 0;   // cycles spent playing since playback started
    logic [31:0] m_audio = '0;
    int          m_und   = 0;
    int          cyc     = 0;

    function automatic bit model_ready();
        return enable && (m_state != 0) && (m_fifo.size() < DEPTH);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        bit do_push;
        if (!reset_n) begin
            m_state = 0;
            m_run   = 0;
            m_audio = '0;
            m_und   = 0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            cyc++;
            do_push = src_valid && model_ready();
            if (!enable) begin
                m_state = 0;
                m_fifo.delete();
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (m_fifo.size() >= PREFILL) begin
                    m_state = 2;
                    m_run   = 0;
                end
            end else begin
                m_run++;
                if (m_run % DIVIDER == 0) begin
                    if (m_fifo.size() > 0) begin
                        m_audio = m_fifo.pop_front();
                    end else begin
                        m_audio = '0;
                        if (m_und < 65535) m_und++;
                        m_state = 1;
                    end
                    exp_q.push_back('{m_audio, cyc});
                end
            end
            if (do_push) m_fifo.push_back(src_data);
        end
    end

    // ---------------- monitor / scoreboard -----------------------------------
    always @(negedge clock) begin
        exp_t e;
        check("state", {30'd0, state}, m_state);
        check("src_ready", {31'd0, src_ready}, {31'd0, model_ready()});
        check("underrun_count", {16'd0, underrun_count}, m_und);
        check("audio_hold", audio, m_audio);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("tick", {31'd0, sample_tick}, 32'd1);
            check("tick_audio", audio, e.audio);
        end else begin
            check("no_tick", {31'd0, sample_tick}, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Offers one sample and holds it until the scheduler has taken it.
    task automatic push_one(input logic [31:0] d);
        bit taken = 0;
        src_valid = 1'b1;
        src_data  = d;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clock);
            taken = src_ready;
            step();
        end
        check("push_accepted", {31'd0, taken}, 32'd1);
    endtask

    initial begin
        int dens;
        int exp_sat;

        reset_n  = 1'b0;
        reset2_n = 1'b0;
        #1;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_audio", audio, 32'd0);
        check("rst_tick", {31'd0, sample_tick}, 32'd0);
        check("rst_under", {16'd0, underrun_count}, 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

        // Prefill and start: 10,20,30,40 back to back.
        enable = 1'b1;
        step();
        push_one(32'd10);
        push_one(32'd20);
        push_one(32'd30);
        push_one(32'd40);
        src_valid = 1'b0;
        @(negedge clock);
        check("full_not_ready", {31'd0, src_ready}, 32'd0);
        step();

        // Drain to underrun, then sit in FILL with nothing arriving.
        repeat (30) step();
        check("underrun_once", {16'd0, underrun_count}, 32'd1);

        // Streaming: keep the FIFO busy so pushes coincide with pops.
        push_one(32'd100);
        push_one(32'd101);
        push_one(32'd102);
        for (int i = 0; i < 40; i++) begin
            src_valid = (i % 4 == 1);
            src_data  = 32'd200 + i;
            step();
        end
        src_valid = 1'b0;

        // Disable on a wrap edge.
        push_one(32'd300);
        push_one(32'd301);
        src_valid = 1'b0;
        for (int k = 0; k < 50 && !(m_state == 2 && (m_run + 1) % DIVIDER == 0); k++) step();
        check("aligned_to_wrap", {30'd0, state}, 32'd2);
        enable = 1'b0;
        step();
        check("disable_idle", {30'd0, state}, 32'd0);
        check("disable_no_tick", {31'd0, sample_tick}, 32'd0);
        repeat (3) step();

        // Async reset mid-period with buffered samples.
        enable = 1'b1;
        step();
        push_one(32'hFFFF_FFF0);
        push_one(32'h8000_0001);
        push_one(32'd7);
        src_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("arst_state", {30'd0, state}, 32'd0);
        check("arst_audio", audio, 32'd0);
        check("arst_tick", {31'd0, sample_tick}, 32'd0);
        check("arst_under", {16'd0, underrun_count}, 32'd0);
        check("arst_ready", {31'd0, src_ready}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Randomized traffic with varying source density.
        dens = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(5, 90);
            enable    = ($urandom_range(0, 99) < 98);
            src_valid = ($urandom_range(0, 99) < dens);
            src_data  = $urandom;
            step();
        end
        enable    = 1'b0;
        src_valid = 1'b0;
        repeat (3) step();

        // Saturation on the second instance: start near the limit.
        reset2_n = 1'b1;
        enable2  = 1'b1;
        step();
        step();
        force dut2.underrun_q = 16'd65530;
        step();
        release dut2.underrun_q;
        exp_sat = 65530;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 20 && state2 != 2'd1; k++) step();
            check("sat_in_fill", {30'd0, state2}, 32'd1);
            check("sat_count", {16'd0, under2}, exp_sat);
            valid2 = 1'b1;
            data2  = 32'd1000 + i;
            step();
            valid2 = 1'b0;
            for (int k = 0; k < 20 && state2 != 2'd2; k++) step();
            check("sat_in_run", {30'd0, state2}, 32'd2);
            if (exp_sat < 65535) exp_sat++;
        end
        for (int k = 0; k < 20 && state2 != 2'd1; k++) step();
        check("sat_final", {16'd0, under2}, 32'd65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_sample_scheduler.md
AUDIO_SAMPLE_SCHEDULER -- requirements
Module: audio_sample_scheduler

Interface
REQ-001 Parameter: DIVIDER, 256, clock cycles per output sample period (legal range 2..65535).
REQ-002 Parameter: DEPTH, 4, sample FIFO depth in entries (power of two, 2..16).
REQ-003 Parameter: PREFILL, 2, FIFO occupancy required before playback starts (legal range 1..DEPTH).
REQ-004 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: enable  input  1  playback enable.
REQ-007 Port: src_valid  input  1  sample source has a sample on src_data.
REQ-008 Port: src_data  input  32  signed sample from source.
REQ-009 Port: src_ready  output  1  scheduler accepts src_data this cycle.
REQ-010 Port: audio  output  32  signed registered sample presented to the output device.
REQ-011 Port: sample_tick  output  1  one-cycle pulse, high in the cycle where audio holds a newly issued sample.
REQ-012 Port: state  output  2  FSM state: 0 IDLE, 1 FILL, 2 RUN.
REQ-013 Port: underrun_count  output  16  saturating count of underrun events.

Function
REQ-014 src_ready SHALL be combinational: enable=1, state!=IDLE, and FIFO not full; there is no bypass when full and popping.
REQ-015 A push SHALL occur on an edge where src_valid=1 and src_ready=1; src_data is written at the FIFO tail.
REQ-016 IDLE: the divider counter SHALL be held at 0 and the FIFO SHALL be flushed; audio SHALL hold its value; sample_tick=0.
REQ-017 IDLE->FILL SHALL occur on the first edge with enable=1.
REQ-018 FILL: the counter SHALL be held at 0 and no ticks are issued.
REQ-019 FILL->RUN SHALL occur on the edge after FIFO occupancy >= PREFILL.
REQ-020 RUN: the counter SHALL increment every cycle, wrapping from DIVIDER-1 to 0.
REQ-021 On each wrap edge in RUN, sample_tick SHALL go high for exactly the next cycle.
REQ-022 On that same wrap edge, if the FIFO is non-empty, the head SHALL be popped into audio.
REQ-023 On that same wrap edge, if the FIFO is empty (underrun), audio SHALL load 0, underrun_count SHALL increment (saturating at 65535), and state SHALL go to FILL.
REQ-024 First tick latency SHALL be DIVIDER cycles after entering RUN.
REQ-025 A simultaneous push and pop on one edge SHALL leave occupancy unchanged and preserve FIFO order.
REQ-026 A push on an underrun edge SHALL be stored, and that sample does not satisfy the pop on the same edge.
REQ-027 enable=0 in any state SHALL force IDLE on the next edge: the FIFO is flushed and any pending wrap on that edge is suppressed (no tick, no pop).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; occupancy is tracked in a $clog2(DEPTH)+1 bit counter.
REQ-029 audio SHALL be passed through as a signed value with no width change.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately set state=IDLE, FIFO empty, counter=0, audio=0, sample_tick=0 and underrun_count=0, independent of clock.
REQ-031 Reset asserted mid-RUN SHALL discard all buffered samples.
REQ-032 Reset deassertion SHALL take effect on the first rising clock edge after reset_n=1.

Verification (DIVIDER=4, DEPTH=4, PREFILL=2)
REQ-033 Prefill and start: enable=1, push 10, 20, 30, 40 back-to-back -> src_ready low after the 4th push, state=RUN one edge after occupancy reaches 2, then audio=10 with tick at cycle 4 of RUN, audio=20 at cycle 8, and ticks exactly 4 cycles apart.
REQ-034 Underrun: after scenario 1, no further pushes -> audio 30, then 40, then 0 at the 5th tick; underrun_count=1; state=FILL; no ticks until 2 new samples are pushed.
REQ-035 Simultaneous push/pop: FIFO holds 3 samples and a push coincides with a wrap -> occupancy stays 3 and the output order matches the push order.
REQ-036 Disable mid-run: enable=0 on a wrap cycle -> no tick, audio unchanged, state=IDLE, FIFO empty, src_ready=0.
REQ-037 Async reset: reset_n=0 mid-period with FIFO non-empty -> all outputs reset before the next clock edge; after release, state=IDLE and underrun_count=0.
REQ-038 Saturation: force 65536 underruns (DIVIDER=2, PREFILL=1, one push per refill) -> underrun_count stays at 65535.
